// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed 4-digit common-anode seven-segment scanner whose value updates are
// frame-aligned. Optional feature macro: LEADING_ZERO_BLANK_EN (blanks leading zero digits above digit 0).

module display_scanner_checker (
  input logic       clk,
  input logic       reset,
  input logic [3:0] anode,
  input logic       frame_done
);

  property p_single_anode;
    @(posedge clk) disable iff (reset) $countones(~anode) <= 1;
  endproperty

  property p_frame_done_pulse;
    @(posedge clk) disable iff (reset) frame_done |=> !frame_done;
  endproperty

  a_single_anode:     assert property (p_single_anode);
  a_frame_done_pulse: assert property (p_frame_done_pulse);

endmodule

module display_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  digit_en,
  output logic [3:0]  nibble,
  output logic [3:0]  anode,
  output logic        frame_done
);

  localparam int              CNT_W      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] SLOT_BLANK = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]       digit_idx_q, digit_idx_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [15:0]      active_q, active_d;
  logic             pending_q, pending_d;
  logic [3:0]       nibble_q, nibble_d;
  logic [3:0]       anode_q, anode_d;
  logic             frame_done_q, frame_done_d;

  logic             slot_wrap_s;
  logic             boundary_s;
  logic [3:0]       suppress_s;

  // Slot counter and digit index advance.
  always_comb begin
    slot_wrap_s = (slot_cnt_q == SLOT_LAST);
    boundary_s  = slot_wrap_s && (digit_idx_q == 2'd3);
    slot_cnt_d  = slot_cnt_q;
    digit_idx_d = digit_idx_q;
    if (slot_wrap_s) begin
      slot_cnt_d  = {CNT_W{1'b0}};
      digit_idx_d = digit_idx_q + 2'd1;
    end else begin
      slot_cnt_d  = slot_cnt_q + CNT_W'(1);
      digit_idx_d = digit_idx_q;
    end
  end

  // A load on the boundary cycle goes straight to active; otherwise it waits in shadow.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (boundary_s) begin
      if (load) begin
        active_d = value;
      end else if (pending_q) begin
        active_d = shadow_q;
      end else begin
        active_d = active_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      shadow_d  = value;
      pending_d = 1'b1;
    end else begin
      shadow_d  = shadow_q;
      pending_d = pending_q;
    end
  end

  // Leading-zero suppression looks only at active, so it is stable across a frame.
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    suppress_s = {(active_q[15:12] == 4'h0),
                  (active_q[15:8]  == 8'h00),
                  (active_q[15:4]  == 12'h000),
                  1'b0};
`else
    suppress_s = 4'b0000;
`endif
  end

  // Output next-state: nibble select, gated anode and frame pulse.
  always_comb begin
    nibble_d     = 4'h0;
    anode_d      = 4'hF;
    frame_done_d = boundary_s;
    case (digit_idx_q)
      2'd0:    nibble_d = active_q[3:0];
      2'd1:    nibble_d = active_q[7:4];
      2'd2:    nibble_d = active_q[11:8];
      2'd3:    nibble_d = active_q[15:12];
      default: nibble_d = 4'h0;
    endcase
    if ((slot_cnt_q >= SLOT_BLANK) && digit_en[digit_idx_q] && !suppress_s[digit_idx_q]) begin
      anode_d[digit_idx_q] = 1'b0;
    end else begin
      anode_d = 4'hF;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt_q   <= {CNT_W{1'b0}};
      digit_idx_q  <= 2'd0;
      shadow_q     <= 16'h0000;
      active_q     <= 16'h0000;
      pending_q    <= 1'b0;
      nibble_q     <= 4'h0;
      anode_q      <= 4'hF;
      frame_done_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      digit_idx_q  <= digit_idx_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      nibble_q     <= nibble_d;
      anode_q      <= anode_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign nibble     = nibble_q;
  assign anode      = anode_q;
  assign frame_done = frame_done_q;

  display_scanner_checker u_checker (
    .clk        (clk),
    .reset      (reset),
    .anode      (anode_q),
    .frame_done (frame_done_q)
  );

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner: directed scenarios plus random loads/enables,
// compared each cycle against a frame-position model (REFRESH_DIV=8, BLANK_CYCLES=2).

module tb_display_scanner;

  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * RD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  digit_en = 4'hF;
  logic [3:0]  nibble;
  logic [3:0]  anode;
  logic        frame_done;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: position within the frame, the value on display and any queued value.
  int          pos = 0;
  logic [15:0] disp = 16'h0000;
  logic [15:0] pend_val = 16'h0000;
  bit          pend = 1'b0;

  display_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .load       (load),
    .digit_en   (digit_en),
    .nibble     (nibble),
    .anode      (anode),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] model_anode(int p, logic [3:0] en, logic [15:0] d);
    int dig;
    logic [3:0] a;
    dig = p / RD;
    a = 4'hF;
    if ((p % RD) >= BC && en[dig]) begin
`ifdef LEADING_ZERO_BLANK_EN
      if (dig == 0 || (d >> (4 * dig)) != 16'h0000) a[dig] = 1'b0;
`else
      a[dig] = 1'b0;
`endif
    end
    return a;
  endfunction

  task automatic tick(input logic ld, input logic [15:0] val);
    logic [3:0] e_an;
    logic [3:0] e_nib;
    logic       e_fd;
    load  = ld;
    value = val;
    if (reset) begin
      e_an = 4'hF; e_nib = 4'h0; e_fd = 1'b0;
    end else begin
      e_an  = model_anode(pos, digit_en, disp);
      e_nib = 4'(disp >> (4 * (pos / RD)));
      e_fd  = (pos == FRAME - 1);
    end
    @(posedge clk);
    #1;
    n_assert++;
    assert (anode === e_an) else begin
      n_fail++;
      $error("FAIL anode pos=%0d observed=%b expected=%b", pos, anode, e_an);
    end
    n_assert++;
    assert (nibble === e_nib) else begin
      n_fail++;
      $error("FAIL nibble pos=%0d observed=%h expected=%h", pos, nibble, e_nib);
    end
    n_assert++;
    assert (frame_done === e_fd) else begin
      n_fail++;
      $error("FAIL frame_done pos=%0d observed=%b expected=%b", pos, frame_done, e_fd);
    end
    if (reset) begin
      pos = 0; disp = 16'h0000; pend = 1'b0; pend_val = 16'h0000;
    end else begin
      if (pos == FRAME - 1) begin
        if (ld) begin
          disp = val; pend = 1'b0;
        end else if (pend) begin
          disp = pend_val; pend = 1'b0;
        end
      end else if (ld) begin
        pend_val = val; pend = 1'b1;
      end
      pos = (pos + 1) % FRAME;
    end
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 16'h0000);
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < FRAME && pos != target; i++) tick(1'b0, 16'h0000);
  endtask

  initial begin
    // Reset held for three cycles.
    reset = 1'b1;
    repeat (3) tick(1'b0, 16'h0000);
    reset = 1'b0;

    // Scan order with 1234.
    tick(1'b1, 16'h1234);
    run(2 * FRAME);

    // Mid-frame load waits for the boundary; then a boundary-cycle load.
    run_to(10);
    tick(1'b1, 16'hABCD);
    run_to(FRAME - 1);
    run(FRAME);
    tick(1'b1, 16'h5555);
    run(FRAME);

    // Digit enable pattern.
    digit_en = 4'b0101;
    run(FRAME);
    digit_en = 4'hF;

    // Leading zeros.
    tick(1'b1, 16'h0030);
    run(2 * FRAME);
    tick(1'b1, 16'h0000);
    run(2 * FRAME);

    // Random loads and enable changes.
    repeat (400) begin
      if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom);
      tick($urandom_range(0, 9) == 0, 16'($urandom));
    end
    digit_en = 4'hF;

    // Reset during slot 2 with a load pending.
    tick(1'b1, 16'h4321);
    run_to(FRAME - 1);
    tick(1'b0, 16'h0000);
    run_to(2 * RD + 3);
    tick(1'b1, 16'h9876);
    reset = 1'b1;
    repeat (2) tick(1'b0, 16'h0000);
    reset = 1'b0;
    run(2 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexed driver for a 4-digit common-anode seven-segment display. It sits directly upstream of the seven_segment decoder: it holds a 16-bit value, scans its four hex nibbles one digit at a time, and presents the current nibble to the decoder while driving the matching active-low anode. Captured values are applied only at frame boundaries, so a displayed frame never mixes old and new data. A dead-time blank at the start of each digit slot suppresses ghosting.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz); must be ≥ 2.
- `BLANK_CYCLES`, default 16: cycles at the start of each slot with all anodes off; must be < `REFRESH_DIV`.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `value`  in  16  display data; digit *i* shows `value[4i+3:4i]`.
- `load`  in  1  single-cycle strobe; captures `value` for the next frame.
- `digit_en`  in  4  per-digit enable; a 0 keeps that anode off during its slot.
- `nibble`  out  4  current digit's nibble, fed to the decoder's `in`.
- `anode`  out  4  active-low anode selects; bit *i* drives digit *i*.
- `frame_done`  out  1  one-cycle pulse when a frame ends.

## Operation
- Registers:
  - `slot_cnt`: 0..`REFRESH_DIV`-1.
  - `digit_idx`: 0..3.
  - `shadow`: 16 bits.
  - `active`: 16 bits.
  - `pending`: 1 bit.
- `slot_cnt` increments every cycle and wraps to 0 after `REFRESH_DIV`-1. On that wrap, `digit_idx` advances (3 → 0).
- Frame boundary: the cycle where `slot_cnt` = `REFRESH_DIV`-1 and `digit_idx` = 3.
  - `frame_done` is 1 on the next cycle.
  - If `pending` or `load` is set, `active` ← (`load` ? `value` : `shadow`) and `pending` clears.
- `load` outside a boundary: `shadow` ← `value`, `pending` ← 1. Repeated loads within one frame keep only the last value.
- `nibble` = `active[4·digit_idx+3 : 4·digit_idx]`, registered.
- `anode[i]` = 0 only when all of the following hold; otherwise all anodes are 1:
  - i = `digit_idx`;
  - `slot_cnt` ≥ `BLANK_CYCLES`;
  - `digit_en[i]` = 1;
  - the digit is not suppressed (see Configuration).
- At most one anode bit is low at any time.
- `digit_en` is sampled combinationally each cycle. A change mid-slot takes effect on the next cycle.

## Timing
- Reset values: `anode` = 4'b1111, `nibble` = 0, `frame_done` = 0. All internal registers reset to 0.
- `reset` asserted mid-frame aborts the scan. A pending load is discarded. The first cycle after reset starts a blanked slot for digit 0.
- All outputs are registered. Each output reflects the `slot_cnt`/`digit_idx` state one cycle after that state is reached, so decoder input and anode switch on the same edge.
- Load-to-display latency is at most one frame (4·`REFRESH_DIV` cycles) plus 1 cycle.
- Each digit is lit for `REFRESH_DIV`-`BLANK_CYCLES` cycles per frame. The frame period is exactly 4·`REFRESH_DIV` cycles.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - Digit *i* (i ≥ 1) is suppressed (anode kept at 1) if its nibble and every higher nibble of `active` are 0.
  - Digit 0 is never suppressed.
  - Suppression is evaluated on `active`, so it changes only at frame boundaries.
- `LEADING_ZERO_BLANK_EN` undefined: no suppression; only `digit_en` and the blank window gate the anodes.

## Test plan
Use `REFRESH_DIV` = 8 and `BLANK_CYCLES` = 2 for all scenarios.
- **Reset:** hold `reset` for 3 cycles → `anode` = 1111, `nibble` = 0, `frame_done` = 0. After release, `anode` = 1110 from cycle 3 to cycle 8 of the first slot.
- **Scan order:** load 16'h1234 and wait one frame → nibbles cycle 4, 3, 2, 1 with anodes 1110, 1101, 1011, 0111. Each anode is low for 6 cycles. `frame_done` pulses every 32 cycles.
- **Frame-boundary load:** load 16'hABCD mid-frame while displaying 16'h1234 → remaining digits still show 1234. The next frame shows D, C, B, A. A `load` of 16'h5555 on the boundary cycle itself displays 5555 in the next frame.
- **Digit enable:** `digit_en` = 4'b0101 → `anode` goes low only in slots 0 and 2; slots 1 and 3 stay at 1111.
- **Leading-zero suppression, with `LEADING_ZERO_BLANK_EN` defined:** load 16'h0030 → digits 3 and 2 stay dark; digits 1 and 0 light. Load 16'h0000 → only digit 0 lights, showing 0. Without the macro, all four digits light.
- **Reset mid-operation:** assert `reset` during slot 2 with a load pending → next frame shows 0000, not the pending value.
